// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Data-memory responder for the MEM stage of a MIPS pipeline.
//             Accepts one load/store at a time, inserts WAIT_CYCLES wait
//             states, commits on the edge entering the response cycle and
//             answers with a one-cycle rsp_valid pulse. Drives a stall back
//             to the hazard logic while a request is pending.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             req_valid/req_ready - request handshake (payload held by master)
//             req_we              - 1 = store, 0 = load
//             req_addr/req_wdata  - byte address / store data
//             rsp_valid           - one-cycle completion pulse
//             rsp_rdata/rsp_err   - load data / error flag, valid with rsp_valid
//             stall               - freeze upstream pipeline registers
//  Options  : DMEM_ALIGN_CHECK_EN - when defined, a non-word-aligned address
//             is reported as an error and never writes the array.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              stall
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Counter start value; unused when there are no wait states.
    localparam logic [3:0] c_CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam logic c_ALIGN_EN = 1'b1;
`else
    localparam logic c_ALIGN_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                w_accept;
    logic                w_commit;
    logic                w_src_we;
    logic [ADDR_W-1:0]   w_src_addr;
    logic [DATA_W-1:0]   w_src_wdata;
    logic [ADDR_W-1:0]   w_word;
    logic [IDX_W-1:0]    w_idx;
    logic                w_range_err;
    logic                w_err;

    assign w_accept = (state_q == S_IDLE) && req_valid;

    // With zero wait states the commit happens on the accept edge itself,
    // before the captured copy exists, so the live request is used then.
    assign w_src_we    = (state_q == S_IDLE) ? req_we    : we_q;
    assign w_src_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    assign w_src_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;

    assign w_word      = {2'b00, w_src_addr[ADDR_W-1:2]};
    assign w_idx       = w_src_addr[IDX_W+1:2];
    assign w_range_err = (w_word >= ADDR_W'(DEPTH));
    assign w_err       = w_range_err | (c_ALIGN_EN & (|w_src_addr[1:0]));

    // RESP always returns to IDLE, so entering RESP is exactly state_d==RESP.
    assign w_commit = (state_d == S_RESP);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = c_CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_commit) begin
            err_d   = w_err;
            rdata_d = (!w_src_we && !w_err) ? mem_q[w_idx] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (w_accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    // Storage is not reset; a reset on the commit edge suppresses the write,
    // so an aborted transaction never reaches the array.
    always_ff @(posedge clk) begin
        if (!rst && w_commit && w_src_we && !w_err) begin
            mem_q[w_idx] <= w_src_wdata;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign stall     = req_valid && !rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Purpose  : Directed self-checking bench for dmem_responder (defaults:
//             DEPTH=256, WAIT_CYCLES=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(
        .DATA_W      (32),
        .ADDR_W      (32),
        .DEPTH       (256),
        .WAIT_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .stall     (stall)
    );

    // One complete transaction. Entered and left at posedge+1.
    // lat = number of cycles from the accept cycle to the rsp_valid cycle.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat,
                       output logic stall_ok);
        bit done;
        done     = 1'b0;
        lat      = 0;
        stall_ok = 1'b1;
        rd       = 32'hFFFF_FFFF;
        er       = 1'bx;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge clk);
        if (!(req_ready === 1'b1 && stall === 1'b1)) stall_ok = 1'b0;
        for (int i = 0; i < 16 && !done; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid === 1'b1) begin
                done = 1'b1;
                rd   = rsp_rdata;
                er   = rsp_err;
                if (stall !== 1'b0) stall_ok = 1'b0;
            end else if (stall !== 1'b1) begin
                stall_ok = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++;
        if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h want 00000000", rsp_rdata); end
        checks++;
        if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat; logic sok;
        txn(1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat, sok);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL store_latency got %0d want 3", lat); end
        checks++;
        if (er !== 1'b0) begin errors++; $display("FAIL store_err got %b want 0", er); end
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL store_rdata got %h want 00000000", rd); end
        checks++;
        if (sok !== 1'b1) begin errors++; $display("FAIL store_stall got %b want 1", sok); end
        txn(1'b0, 32'h10, 32'h0, rd, er, lat, sok);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL load_latency got %0d want 3", lat); end
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata got %h want deadbeef", rd); end
        checks++;
        if (er !== 1'b0) begin errors++; $display("FAIL load_err got %b want 0", er); end
        checks++;
        if (sok !== 1'b1) begin errors++; $display("FAIL load_stall got %b want 1", sok); end
    endtask

    task automatic test_range_err();
        logic [31:0] rd; logic er; int lat; logic sok;
        txn(1'b1, 32'h0, 32'hA5A50001, rd, er, lat, sok);
        txn(1'b0, 32'h400, 32'h0, rd, er, lat, sok);
        checks++;
        if (er !== 1'b1) begin errors++; $display("FAIL range_err got %b want 1", er); end
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL range_rdata got %h want 00000000", rd); end
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL range_latency got %0d want 3", lat); end
        txn(1'b1, 32'h3FC, 32'h0C0FFEE0, rd, er, lat, sok);
        checks++;
        if (er !== 1'b0) begin errors++; $display("FAIL last_word_err got %b want 0", er); end
        txn(1'b0, 32'h0, 32'h0, rd, er, lat, sok);
        checks++;
        if (rd !== 32'hA5A50001) begin errors++; $display("FAIL range_word0 got %h want a5a50001", rd); end
        checks++;
        if (er !== 1'b0) begin errors++; $display("FAIL range_word0_err got %b want 0", er); end
        txn(1'b0, 32'h3FC, 32'h0, rd, er, lat, sok);
        checks++;
        if (rd !== 32'h0C0FFEE0) begin errors++; $display("FAIL last_word_rdata got %h want 0c0ffee0", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat; logic sok;
        int t_prev;
        int t_now;
        bit seen;
        t_prev    = 0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0;
        req_wdata = 32'h0BAD0000;
        for (int k = 0; k < 4; k++) begin
            seen = 1'b0;
            for (int i = 0; i < 16 && !seen; i++) begin
                @(negedge clk);
                if (rsp_valid === 1'b1) seen = 1'b1;
            end
            t_now = cyc;
            checks++;
            if (!seen) begin errors++; $display("FAIL b2b_timeout pulse %0d got none want pulse", k); end
            if (k > 0) begin
                checks++;
                if (t_now - t_prev !== 4) begin
                    errors++; $display("FAIL b2b_spacing pulse %0d got %0d want 4", k, t_now - t_prev);
                end
            end
            t_prev = t_now;
            @(posedge clk);
            #1;
            if (k < 3) begin
                req_addr  = 32'(4 * (k + 1));
                req_wdata = 32'h0BAD0000 | 32'(k + 1);
            end else begin
                req_valid = 1'b0;
                req_we    = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse_width pulse %0d got %b want 0", k, rsp_valid); end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            txn(1'b0, 32'(4 * k), 32'h0, rd, er, lat, sok);
            checks++;
            if (rd !== (32'h0BAD0000 | 32'(k))) begin
                errors++; $display("FAIL b2b_read word %0d got %h want %h", k, rd, 32'h0BAD0000 | 32'(k));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; logic sok;
        bit seen;
        txn(1'b1, 32'h20, 32'h0, rd, er, lat, sok);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        rst  = 1'b1;
        seen = 1'b0;
        @(negedge clk);
        if (rsp_valid === 1'b1) seen = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL rstmid_rsp_valid got 1 want 0"); end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", req_ready); end
        @(posedge clk);
        #1;
        txn(1'b0, 32'h20, 32'h0, rd, er, lat, sok);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL rstmid_load got %h want 00000000", rd); end
    endtask

    task automatic test_align();
        logic [31:0] rd; logic er; int lat; logic sok;
        logic        exp_err;
        logic [31:0] exp_word;
`ifdef DMEM_ALIGN_CHECK_EN
        exp_err  = 1'b1;
        exp_word = 32'h11111111;
`else
        exp_err  = 1'b0;
        exp_word = 32'hCAFEF00D;
`endif
        txn(1'b1, 32'h20, 32'h11111111, rd, er, lat, sok);
        txn(1'b1, 32'h22, 32'hCAFEF00D, rd, er, lat, sok);
        checks++;
        if (er !== exp_err) begin errors++; $display("FAIL align_err got %b want %b", er, exp_err); end
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL align_latency got %0d want 3", lat); end
        txn(1'b0, 32'h20, 32'h0, rd, er, lat, sok);
        checks++;
        if (rd !== exp_word) begin errors++; $display("FAIL align_word got %h want %h", rd, exp_word); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_range_err();
        test_back_to_back();
        test_reset_mid();
        test_align();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
